// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with fill count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional FWFT read mode.
module param_sync_fifo #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        i_wrdata,
    input  logic                     i_wren,
    input  logic                     i_rden,
    input  logic                     i_clr,
    output logic [DATA_W-1:0]        o_rddata,
    output logic                     o_rdvalid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_alm_full,
    output logic                     o_alm_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_ok;
    logic              wr_ok;
    logic [CNT_W-1:0]  count_next;

    // Accept logic: a full FIFO still takes a write when a read frees a slot on the same edge
    always_comb begin
        rd_ok      = i_rden && !o_empty;
        wr_ok      = i_wren && (!o_full || rd_ok);
        count_next = o_count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end

    // Pointers, count and status flags; flags track count_next so they move with o_count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_alm_full  <= 1'b0;
            o_alm_empty <= 1'b1;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_alm_full  <= 1'b0;
            o_alm_empty <= 1'b1;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_count     <= count_next;
            o_full      <= (count_next == DEPTH_CNT);
            o_empty     <= (count_next == '0);
            o_alm_full  <= (count_next >= AF_CNT);
            o_alm_empty <= (count_next <= AE_CNT);
            if (i_wren && o_full && !rd_ok) begin
                o_overflow <= 1'b1;
            end
            if (i_rden && o_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end

    // Storage array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_ok && !i_clr) begin
            mem[wr_ptr] <= i_wrdata;
        end
    end

    // Last popped word; also what an empty FWFT FIFO presents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_ok && !i_clr) begin
            rd_data_q <= mem[rd_ptr];
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic rd_valid_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_valid_q <= 1'b0;
                end else if (i_clr) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                end
            end

            assign o_rddata  = rd_data_q;
            assign o_rdvalid = rd_valid_q;
        end else begin : g_fwft
            // Head word is shown straight from the array once it is committed
            assign o_rddata  = o_empty ? rd_data_q : mem[rd_ptr];
            assign o_rdvalid = !o_empty;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a standard-mode and an FWFT instance share
// the same stimulus; table vectors plus hand-written multi-cycle sequences.
module tb_param_sync_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wrdata;
    logic       wren, rden, clr;

    logic [7:0] s_rddata, f_rddata;
    logic       s_rdvalid, f_rdvalid, s_full, f_full, s_empty, f_empty;
    logic       s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_unf, f_unf;
    logic [4:0] s_count, f_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .reset(reset), .i_wrdata(wrdata), .i_wren(wren), .i_rden(rden), .i_clr(clr),
        .o_rddata(s_rddata), .o_rdvalid(s_rdvalid), .o_full(s_full), .o_empty(s_empty),
        .o_alm_full(s_af), .o_alm_empty(s_ae), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_unf)
    );

    param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .i_wrdata(wrdata), .i_wren(wren), .i_rden(rden), .i_clr(clr),
        .o_rddata(f_rddata), .o_rdvalid(f_rdvalid), .o_full(f_full), .o_empty(f_empty),
        .o_alm_full(f_af), .o_alm_empty(f_ae), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf)
    );

    typedef struct {
        logic       wren, rden, clr;
        logic [7:0] wdata;
        logic [4:0] cnt;
        logic       full, empty, af, ae, ovf, unf, rdv;
        logic       chk_d;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int wr, input int rd, input int cl, input int wd,
                                input int cnt, input int fu, input int em, input int af,
                                input int ae, input int ov, input int un, input int rv,
                                input int cd, input int rdat);
        vec_t v;
        v.wren  = 1'(wr);  v.rden = 1'(rd); v.clr = 1'(cl); v.wdata = 8'(wd);
        v.cnt   = 5'(cnt); v.full = 1'(fu); v.empty = 1'(em);
        v.af    = 1'(af);  v.ae   = 1'(ae); v.ovf = 1'(ov); v.unf = 1'(un);
        v.rdv   = 1'(rv);  v.chk_d = 1'(cd); v.rdata = 8'(rdat);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
        wren = w; rden = r; clr = c; wrdata = d;
    endtask

    // One clock: inputs already applied, sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " count"},   32'(s_count),   32'd0);
        chk({tag, " empty"},   32'(s_empty),   32'd1);
        chk({tag, " ae"},      32'(s_ae),      32'd1);
        chk({tag, " full"},    32'(s_full),    32'd0);
        chk({tag, " af"},      32'(s_af),      32'd0);
        chk({tag, " rdvalid"}, 32'(s_rdvalid), 32'd0);
        chk({tag, " rddata"},  32'(s_rddata),  32'd0);
        chk({tag, " ovf"},     32'(s_ovf),     32'd0);
        chk({tag, " unf"},     32'(s_unf),     32'd0);
        chk({tag, " f_rdvalid"}, 32'(f_rdvalid), 32'd0);
        chk({tag, " f_rddata"},  32'(f_rddata),  32'd0);
        chk({tag, " f_count"},   32'(f_count),   32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #3;
        chk_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill, full-with-read, overflow, drain, underflow, empty rd+wr, flush
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 0, i, i + 1, int'(i + 1 == 16), 0, int'(i + 1 >= 14),
                             int'(i + 1 <= 2), 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 'h10, 16, 1, 0, 1, 0, 0, 0, 1, 1, 'h00));
        tbl.push_back(mk(1, 0, 0, 'hEE, 16, 1, 0, 1, 0, 1, 0, 0, 1, 'h00));
        for (int j = 0; j < 16; j++) begin
            int c;
            c = 15 - j;
            tbl.push_back(mk(0, 1, 0, 0, c, 0, int'(c == 0), int'(c >= 14), int'(c <= 2),
                             1, 0, 1, 1, j + 1));
        end
        tbl.push_back(mk(0, 1, 0, 0,     0, 0, 1, 0, 1, 1, 1, 0, 1, 'h10));
        tbl.push_back(mk(1, 1, 0, 'h55,  1, 0, 0, 0, 1, 1, 1, 0, 1, 'h10));
        tbl.push_back(mk(1, 0, 1, 'h66,  0, 0, 1, 0, 1, 0, 0, 0, 1, 'h10));
        tbl.push_back(mk(0, 0, 0, 0,     0, 0, 1, 0, 1, 0, 0, 0, 1, 'h10));

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].wren, tbl[i].rden, tbl[i].clr, tbl[i].wdata);
            tick();
            chk({t, " count"},   32'(s_count),   32'(tbl[i].cnt));
            chk({t, " full"},    32'(s_full),    32'(tbl[i].full));
            chk({t, " empty"},   32'(s_empty),   32'(tbl[i].empty));
            chk({t, " af"},      32'(s_af),      32'(tbl[i].af));
            chk({t, " ae"},      32'(s_ae),      32'(tbl[i].ae));
            chk({t, " ovf"},     32'(s_ovf),     32'(tbl[i].ovf));
            chk({t, " unf"},     32'(s_unf),     32'(tbl[i].unf));
            chk({t, " rdvalid"}, 32'(s_rdvalid), 32'(tbl[i].rdv));
            chk({t, " f_rdvalid"}, 32'(f_rdvalid), 32'(!tbl[i].empty));
            chk({t, " f_count"},   32'(f_count),   32'(tbl[i].cnt));
            if (tbl[i].chk_d)
                chk({t, " rddata"}, 32'(s_rddata), 32'(tbl[i].rdata));
        end

        // Prefill 3 then stream 40 through the wrapping pointers
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
            tick();
            if (i == 0) begin
                chk("prefill f_rddata", 32'(f_rddata), 32'h80);
                chk("prefill f_rdvalid", 32'(f_rdvalid), 32'd1);
            end
        end
        chk("prefill count", 32'(s_count), 32'd3);
        for (int k = 0; k < 40; k++) begin
            string t;
            t = $sformatf("stream%0d", k);
            drive(1'b1, 1'b1, 1'b0, 8'(8'h83 + k));
            tick();
            chk({t, " rdvalid"},  32'(s_rdvalid), 32'd1);
            chk({t, " rddata"},   32'(s_rddata),  32'(8'h80 + k));
            chk({t, " count"},    32'(s_count),   32'd3);
            chk({t, " f_rddata"}, 32'(f_rddata),  32'(8'h81 + k));
        end
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            chk($sformatf("tail%0d rddata", j), 32'(s_rddata), 32'(8'hA8 + j));
        end
        chk("tail empty", 32'(s_empty), 32'd1);

        // FWFT: a single word shows without a read, a read pops it
        drive(1'b1, 1'b0, 1'b0, 8'hA5);
        tick();
        chk("fwft a5 data",   32'(f_rddata),  32'hA5);
        chk("fwft a5 valid",  32'(f_rdvalid), 32'd1);
        chk("std a5 novalid", 32'(s_rdvalid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("fwft a5 hold",   32'(f_rddata),  32'hA5);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        chk("fwft pop empty", 32'(f_empty),   32'd1);
        chk("fwft pop valid", 32'(f_rdvalid), 32'd0);
        chk("std a5 data",    32'(s_rddata),  32'hA5);
        chk("std a5 valid",   32'(s_rdvalid), 32'd1);

        // Reach count 10 with overflow set, then flush together with a write
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            tick();
        end
        chk("pre-clr count", 32'(s_count), 32'd10);
        chk("pre-clr ovf",   32'(s_ovf),   32'd1);
        drive(1'b1, 1'b0, 1'b1, 8'h77);
        tick();
        chk("clr count", 32'(s_count), 32'd0);
        chk("clr empty", 32'(s_empty), 32'd1);
        chk("clr ovf",   32'(s_ovf),   32'd0);
        chk("clr af",    32'(s_af),    32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("clr discard count", 32'(s_count), 32'd0);

        // Reset asserted mid-stream with underflow pending
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        chk("pre-rst unf", 32'(s_unf), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 8'h30);
        tick();
        chk("pre-rst rdvalid", 32'(s_rdvalid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("midrst");
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h3C);
        tick();
        chk("post-rst count", 32'(s_count), 32'd1);
        chk("post-rst f_rddata", 32'(f_rddata), 32'h3C);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        chk("post-rst rddata", 32'(s_rddata), 32'h3C);
        chk("post-rst empty",  32'(s_empty),  32'd1);
        chk("post-rst unf",    32'(s_unf),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
